// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared MVU product signedness encodings and lane extension helper
package mvu_pkg;

   localparam int OP_UNS     = 0;
   localparam int OP_ACT_SGN = 1;
   localparam int OP_WGT_SGN = 2;
   localparam int OP_ALL_SGN = 3;

   localparam int LANE_MAXW  = 64;

   // Any non-zero encoding means the product itself is signed.
   function automatic logic [LANE_MAXW-1:0] ext_lane(
      input logic [LANE_MAXW-1:0] lane,
      input int                   ti,
      input int                   op_sgn
   );
      logic                 sgn;
      logic [LANE_MAXW-1:0] r;
      sgn = (op_sgn != OP_UNS) && lane[6'(ti - 1)];
      r   = '0;
      for (int i = 0; i < LANE_MAXW; i++) begin
         r[6'(i)] = (i < ti) ? lane[6'(i)] : sgn;
      end
      return r;
   endfunction

endpackage

// File: rtl/mvu_pe_adder_tree.sv
// rtl/mvu_pe_adder_tree.sv - combinational reduction of SIMD product lanes to one TDstI sum
module mvu_pe_adder_tree
   import mvu_pkg::*;
#(
   parameter int SIMD   = 2,
   parameter int TI     = 8,
   parameter int TDstI  = 16,
   parameter int OP_SGN = 0
)(
   input  logic [SIMD*TI-1:0] prod_i,
   output logic [TDstI-1:0]   sum_o
);

   logic [LANE_MAXW-1:0] ext;

   always_comb begin
      ext   = '0;
      sum_o = '0;
      for (int k = 0; k < SIMD; k++) begin
         ext   = ext_lane({{(LANE_MAXW-TI){1'b0}}, prod_i[k*TI +: TI]}, TI, OP_SGN);
         sum_o = sum_o + ext[TDstI-1:0];
      end
   end

endmodule

// File: rtl/mvu_pe_acc.sv
// rtl/mvu_pe_acc.sv - PE accumulator: adder tree, SF-beat fold, registered output word
// Optional tree/accumulator register stage enabled by PE_ACC_TREE_PIPE_EN.
module mvu_pe_acc
   import mvu_pkg::*;
#(
   parameter int SIMD   = 2,
   parameter int TI     = 8,
   parameter int TDstI  = 16,
   parameter int SF     = 4,
   parameter int OP_SGN = OP_UNS
)(
   input  logic               aclk,
   input  logic               areset,
   input  logic               in_v,
   output logic               in_rdy,
   input  logic [SIMD*TI-1:0] in_prod,
   output logic               out_v,
   input  logic               out_rdy,
   output logic [TDstI-1:0]   out
);

   localparam int CW = (SF > 1) ? $clog2(SF) : 1;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TDstI-1:0] acc_q, acc_d;
   logic [TDstI-1:0] out_q, out_d;
   logic             out_v_q, out_v_d;

   logic [TDstI-1:0] tree_sum;
   logic             in_fire;
   logic             in_last;
   logic             slot_free;

   // Beat presented to the accumulator this cycle.
   logic             acc_v;
   logic             acc_last;
   logic [TDstI-1:0] acc_sum;

   mvu_pe_adder_tree #(
      .SIMD   (SIMD),
      .TI     (TI),
      .TDstI  (TDstI),
      .OP_SGN (OP_SGN)
   ) u_tree (
      .prod_i (in_prod),
      .sum_o  (tree_sum)
   );

   assign slot_free = ~out_v_q | out_rdy;
   assign in_fire   = in_v & in_rdy;
   assign in_last   = (cnt_q == CW'(SF - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (in_fire) begin
         cnt_d = in_last ? '0 : cnt_q + 1'b1;
      end
   end

`ifdef PE_ACC_TREE_PIPE_EN
   logic             stg_v_q, stg_v_d;
   logic             stg_last_q, stg_last_d;
   logic [TDstI-1:0] stg_sum_q, stg_sum_d;
   logic             stg_adv;

   // Only a last beat needs the output slot; partial beats always drain.
   assign stg_adv  = stg_v_q & (~stg_last_q | slot_free);
   assign in_rdy   = ~stg_v_q | stg_adv;
   assign acc_v    = stg_adv;
   assign acc_last = stg_last_q;
   assign acc_sum  = stg_sum_q;

   always_comb begin
      stg_v_d    = stg_v_q;
      stg_last_d = stg_last_q;
      stg_sum_d  = stg_sum_q;
      if (in_fire) begin
         stg_v_d    = 1'b1;
         stg_last_d = in_last;
         stg_sum_d  = tree_sum;
      end else if (stg_adv) begin
         stg_v_d    = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stg_v_q    <= 1'b0;
         stg_last_q <= 1'b0;
         stg_sum_q  <= '0;
      end else begin
         stg_v_q    <= stg_v_d;
         stg_last_q <= stg_last_d;
         stg_sum_q  <= stg_sum_d;
      end
   end
`else
   assign in_rdy   = slot_free;
   assign acc_v    = in_fire;
   assign acc_last = in_last;
   assign acc_sum  = tree_sum;
`endif

   // A final beat dumps into the output register and restarts the fold from zero.
   always_comb begin
      acc_d   = acc_q;
      out_d   = out_q;
      out_v_d = out_v_q;
      if (out_v_q & out_rdy) begin
         out_v_d = 1'b0;
      end
      if (acc_v) begin
         if (acc_last) begin
            out_d   = acc_q + acc_sum;
            out_v_d = 1'b1;
            acc_d   = '0;
         end else begin
            acc_d   = acc_q + acc_sum;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         out_v_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         out_v_q <= out_v_d;
      end
   end

   assign out_v = out_v_q;
   assign out   = out_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// tb/tb_mvu_pe_acc.sv - scoreboard bench for mvu_pe_acc (default, signed and 9-bit overflow builds)
module tb_mvu_pe_acc;

`ifdef PE_ACC_TREE_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic        in_v;
   logic [15:0] in_prod;
   logic        en0, en1, en2;

   logic        in_rdy0, out_v0, out_rdy0;
   logic [15:0] out0;
   logic        in_rdy1, out_v1;
   logic [15:0] out1;
   logic        in_rdy2, out_v2;
   logic [8:0]  out2;
   logic        in_v0, in_v1, in_v2;
   logic        out_rdy1, out_rdy2;

   int vectors;
   int miscompares;
   int stalls;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] q2[$];

   assign in_v0    = in_v & en0;
   assign in_v1    = in_v & en1;
   assign in_v2    = in_v & en2;
   assign out_rdy1 = 1'b1;
   assign out_rdy2 = 1'b1;

   mvu_pe_acc #(.SIMD(2), .TI(8), .TDstI(16), .SF(4), .OP_SGN(0)) u0 (
      .aclk(clk), .areset(rst), .in_v(in_v0), .in_rdy(in_rdy0), .in_prod(in_prod),
      .out_v(out_v0), .out_rdy(out_rdy0), .out(out0)
   );

   mvu_pe_acc #(.SIMD(2), .TI(8), .TDstI(16), .SF(4), .OP_SGN(3)) u1 (
      .aclk(clk), .areset(rst), .in_v(in_v1), .in_rdy(in_rdy1), .in_prod(in_prod),
      .out_v(out_v1), .out_rdy(out_rdy1), .out(out1)
   );

   mvu_pe_acc #(.SIMD(2), .TI(8), .TDstI(9), .SF(2), .OP_SGN(0)) u2 (
      .aclk(clk), .areset(rst), .in_v(in_v2), .in_rdy(in_rdy2), .in_prod(in_prod),
      .out_v(out_v2), .out_rdy(out_rdy2), .out(out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One beat: lane0 = l0, lane1 = l1; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] l0, input logic [7:0] l1);
      bit ok;
      int n;
      in_prod = {l1, l0};
      in_v    = 1'b1;
      ok      = 1'b0;
      n       = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = (!en0 || in_rdy0) && (!en1 || in_rdy1) && (!en2 || in_rdy2);
         @(posedge clk);
         #1;
         n++;
         if (!ok) stalls++;
      end
      in_v = 1'b0;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: beat %0h/%0h not accepted within 100 cycles", l0, l1);
      end
   endtask

   // Scoreboard monitors: a word transfers on the edge following a negedge with valid & ready.
   initial forever begin
      @(negedge clk);
      if (!rst && out_v0 && out_rdy0) begin
         if (q0.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL u0_unexpected: got %0h expected no output", out0);
         end else chk("u0_out", out0, q0.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst && out_v1 && out_rdy1) begin
         if (q1.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL u1_unexpected: got %0h expected no output", out1);
         end else chk("u1_out", out1, q1.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst && out_v2 && out_rdy2) begin
         if (q2.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL u2_unexpected: got %0h expected no output", out2);
         end else chk("u2_out", out2, q2.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vectors = 0; miscompares = 0; stalls = 0;
      rst = 1'b1; in_v = 1'b0; in_prod = '0;
      en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; out_rdy0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_v0", out_v0, 0);
      chk("rst_out0", out0, 0);
      chk("rst_in_rdy0", in_rdy0, 1);
      chk("rst_out_v1", out_v1, 0);
      chk("rst_out_v2", out_v2, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic unsigned fold and single-pulse latency.
      en0 = 1'b1;
      q0.push_back(32'd24);
      send(3, 4); send(1, 1); send(10, 0); send(0, 5);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("t1_latency", out_v0, (k == LAT) ? 1 : 0);
      end
      @(posedge clk); #1;

      // Same lanes, unsigned vs fully signed.
      en1 = 1'b1;
      q0.push_back(32'h0404);
      q1.push_back(32'h0004);
      repeat (4) send(8'hFF, 8'h02);
      en1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Back-to-back neurons with no gaps.
      q0.push_back(32'd36);
      q0.push_back(32'd172);
      stalls = 0;
      send(1, 2); send(3, 4); send(5, 6); send(7, 8);
      send(100, 0); send(0, 50); send(10, 10); send(1, 1);
      chk("t3_no_bubble", stalls, 0);
      repeat (LAT + 3) @(posedge clk);
      #1;

      // Downstream stall with further neurons queued behind the held result.
      out_rdy0 = 1'b0;
      q0.push_back(32'd8);
      repeat (4) send(1, 1);
      q0.push_back(32'd20);
      q0.push_back(32'd28);
      fork
         begin
            repeat (4) send(2, 3);
            send(0, 9); send(9, 0); send(1, 2); send(3, 4);
         end
         begin
            repeat (2) @(posedge clk);
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               chk("t4_held_v", out_v0, 1);
               chk("t4_held_out", out0, 8);
            end
            chk("t4_in_rdy_low", in_rdy0, 0);
            @(posedge clk);
            #1;
            out_rdy0 = 1'b1;
         end
      join
      repeat (LAT + 4) @(posedge clk);
      #1;

      // 9-bit accumulator wraps.
      en0 = 1'b0;
      en2 = 1'b1;
      q2.push_back(32'd508);
      send(255, 255); send(255, 255);
      en2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset mid-fold discards partial sum.
      en0 = 1'b1;
      send(5, 5); send(7, 7);
      rst = 1'b1;
      #1;
      chk("t6_rst_out_v", out_v0, 0);
      chk("t6_rst_out", out0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q0.push_back(32'd8);
      repeat (4) send(1, 1);
      repeat (LAT + 4) @(posedge clk);
      #1;

      chk("end_q0_empty", q0.size(), 0);
      chk("end_q1_empty", q1.size(), 0);
      chk("end_q2_empty", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
